// File: rtl/uba_intr_arb.sv
// uba_intr_arb: Unibus BR4..BR7 interrupt aggregation, arbitration and vector-cycle sequencing
module uba_intr_arb #(
  parameter int NDEV     = 8,
  parameter int VWIDTH   = 18,
  parameter int TMOWIDTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NDEV-1:0]     devREQ,
  input  logic [2*NDEV-1:0]   devBR,
  output logic [NDEV-1:0]     devACK,
  input  logic [VWIDTH-1:0]   devVECT,
  input  logic                devVECTVAL,
  output logic [3:0]          devINTR,
  input  logic [2:0]          statPIH,
  input  logic [2:0]          statPIL,
  input  logic                ivecREQ,
  input  logic [2:0]          ivecPI,
  output logic                ivecACK,
  output logic [VWIDTH-1:0]   ivecDATA,
  output logic                ivecNONE
);
  typedef enum logic [1:0] {IDLE, ARB, GRANT, DONE} state_t;
  state_t state, state_n;
  logic [2:0] pil, pil_n;
  logic [TMOWIDTH-1:0] timer, timer_n;
  logic [3:0][NDEV-1:0] lvl_req;
  logic [NDEV-1:0] sel, win, devack_n;
  logic elig_h, elig_l, tmo, fin, ack_n, none_n;
  logic [VWIDTH-1:0] data_n;
  // requests split by BR level (index 0 = BR4)
  always_comb begin
    lvl_req = '0;
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < NDEV; i++)
        lvl_req[l][i] = devREQ[i] && devBR[2*i +: 2] == 2'(l);
  end
  // highest eligible level with a request, then lowest slot within it
  always_comb begin
    elig_h = statPIH == pil && pil != 3'd0;
    elig_l = statPIL == pil && pil != 3'd0;
    sel = elig_h && |lvl_req[3] ? lvl_req[3] :
          elig_h && |lvl_req[2] ? lvl_req[2] :
          elig_l && |lvl_req[1] ? lvl_req[1] :
          elig_l && |lvl_req[0] ? lvl_req[0] : '0;
    win = sel & (~sel + NDEV'(1));
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next-state logic
  always_comb begin
    tmo = timer == {{(TMOWIDTH-1){1'b1}}, 1'b0};
    fin = devVECTVAL || tmo;
    state_n = state == IDLE  ? (ivecREQ ? ARB : IDLE) :
              state == ARB   ? (|win ? GRANT : IDLE) :
              state == GRANT ? (fin ? DONE : GRANT) : IDLE;
  end
  // next values of the registered outputs and datapath
  always_comb begin
    ack_n    = (state == ARB && !(|win)) || (state == GRANT && fin);
    none_n   = ack_n && !(state == GRANT && devVECTVAL);
    data_n   = ack_n ? (state == GRANT && devVECTVAL ? devVECT : '0) : ivecDATA;
    devack_n = state == ARB ? win : (state == GRANT && !fin ? devACK : '0);
    timer_n  = state == GRANT ? timer + TMOWIDTH'(1) : '0;
    pil_n    = state == IDLE && ivecREQ ? ivecPI : pil;
  end
  // output and datapath registers; devINTR tracks requests in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      devACK   <= '0;
      devINTR  <= '0;
      ivecACK  <= 1'b0;
      ivecDATA <= '0;
      ivecNONE <= 1'b0;
      timer    <= '0;
      pil      <= '0;
    end else begin
      devACK   <= devack_n;
      devINTR  <= {|lvl_req[3], |lvl_req[2], |lvl_req[1], |lvl_req[0]};
      ivecACK  <= ack_n;
      ivecDATA <= data_n;
      ivecNONE <= none_n;
      timer    <= timer_n;
      pil      <= pil_n;
    end
  end
endmodule

// File: tb/tb_uba_intr_arb.sv
// tb_uba_intr_arb: directed vector bench for the Unibus interrupt arbiter
module tb_uba_intr_arb;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] devREQ, devACK;
  logic [15:0] devBR;
  logic [17:0] devVECT, ivecDATA;
  logic devVECTVAL, ivecREQ, ivecACK, ivecNONE;
  logic [3:0] devINTR;
  logic [2:0] statPIH, statPIL, ivecPI;
  int ncmp = 0;
  int nfail = 0;

  uba_intr_arb #(.NDEV(8), .VWIDTH(18), .TMOWIDTH(6)) dut (
    .clk(clk), .rst(rst), .devREQ(devREQ), .devBR(devBR), .devACK(devACK),
    .devVECT(devVECT), .devVECTVAL(devVECTVAL), .devINTR(devINTR),
    .statPIH(statPIH), .statPIL(statPIL), .ivecREQ(ivecREQ), .ivecPI(ivecPI),
    .ivecACK(ivecACK), .ivecDATA(ivecDATA), .ivecNONE(ivecNONE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  req;
    logic [15:0] br;
    logic [2:0]  pih, pil, pi;
    logic [17:0] vect;
    int          d;
    logic [7:0]  eack;
    int          ecyc;
    logic        enone;
    logic [17:0] edata;
    logic [3:0]  eintr;
    logic        extra;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // cycle 0 carries ivecREQ; device answers in cycle 2+d (d<0: never)
  task automatic txn(input string nm, input vec_t v);
    int acks = 0;
    int acyc = -1;
    logic [17:0] adata = '0;
    logic anone = 1'b0;
    logic [7:0] ack2 = '0;
    logic [7:0] ackat = '1;
    logic [3:0] intr = '0;
    devREQ = v.req; devBR = v.br; statPIH = v.pih; statPIL = v.pil; ivecPI = v.pi;
    for (int c = 0; c <= v.ecyc + 3; c++) begin
      ivecREQ = (c == 0) || (v.extra && c == 5);
      devVECTVAL = v.d >= 0 && c == 2 + v.d;
      devVECT = devVECTVAL ? v.vect : 18'h3ffff;
      @(negedge clk);
      if (c == 2) begin ack2 = devACK; intr = devINTR; end
      if (ivecACK) begin
        acks++;
        if (acyc < 0) begin acyc = c; adata = ivecDATA; anone = ivecNONE; ackat = devACK; end
      end
      nxt();
    end
    ivecREQ = 1'b0; devVECTVAL = 1'b0;
    chk({nm, " devACK"}, 32'(ack2), 32'(v.eack));
    chk({nm, " devINTR"}, 32'(intr), 32'(v.eintr));
    chk({nm, " ack_cycle"}, acyc, v.ecyc);
    chk({nm, " ack_count"}, acks, 1);
    chk({nm, " ivecNONE"}, 32'(anone), 32'(v.enone));
    chk({nm, " ivecDATA"}, 32'(adata), 32'(v.edata));
    chk({nm, " devACK_at_ack"}, 32'(ackat), 32'h0);
  endtask

  initial begin
    tv[0] = '{8'h26, 16'h0C0C, 3'd3, 3'd3, 3'd3, 18'o254, 0, 8'h02, 3, 1'b0, 18'o254, 4'b1001, 1'b0};
    tv[1] = '{8'h08, 16'h0080, 3'd5, 3'd2, 3'd2, 18'o111, -1, 8'h00, 2, 1'b1, 18'o0, 4'b0100, 1'b0};
    tv[2] = '{8'hC0, 16'h1000, 3'd1, 3'd2, 3'd2, 18'o1234, 2, 8'h40, 5, 1'b0, 18'o1234, 4'b0011, 1'b0};
    tv[3] = '{8'h01, 16'h0003, 3'd0, 3'd0, 3'd0, 18'o5, -1, 8'h00, 2, 1'b1, 18'o0, 4'b1000, 1'b0};
    tv[4] = '{8'h11, 16'h0200, 3'd4, 3'd4, 3'd4, 18'h2ABCD, 1, 8'h10, 4, 1'b0, 18'h2ABCD, 4'b0101, 1'b0};
    tv[5] = '{8'h00, 16'h0000, 3'd1, 3'd1, 3'd1, 18'o7, -1, 8'h00, 2, 1'b1, 18'o0, 4'b0000, 1'b0};
    tv[6] = '{8'h01, 16'h0003, 3'd3, 3'd0, 3'd3, 18'o700, -1, 8'h01, 65, 1'b1, 18'o0, 4'b1000, 1'b1};
    tv[7] = '{8'h01, 16'h0003, 3'd3, 3'd0, 3'd3, 18'o777, 62, 8'h01, 65, 1'b0, 18'o777, 4'b1000, 1'b0};
    rst = 1'b1; devREQ = '1; devBR = 16'hDDDD; devVECT = '0; devVECTVAL = 1'b0;
    statPIH = 3'd0; statPIL = 3'd0; ivecREQ = 1'b0; ivecPI = 3'd0;
    repeat (3) nxt();
    @(negedge clk);
    chk("reset devINTR", 32'(devINTR), 32'h0);
    chk("reset devACK", 32'(devACK), 32'h0);
    chk("reset ivecACK", 32'(ivecACK), 32'h0);
    chk("reset ivecDATA", 32'(ivecDATA), 32'h0);
    chk("reset ivecNONE", 32'(ivecNONE), 32'h0);
    nxt();
    rst = 1'b0;
    nxt();
    @(negedge clk);
    chk("release devINTR", 32'(devINTR), 32'hA);
    nxt();
    for (int k = 0; k < 8; k++) txn($sformatf("vec%0d", k), tv[k]);
    // reset while the grant is outstanding
    devREQ = 8'h01; devBR = 16'h0003; statPIH = 3'd3; ivecPI = 3'd3; ivecREQ = 1'b1;
    nxt();
    ivecREQ = 1'b0;
    nxt();
    @(negedge clk);
    chk("midrst devACK_before", 32'(devACK), 32'h01);
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst devACK_after", 32'(devACK), 32'h0);
    chk("midrst ivecACK_after", 32'(ivecACK), 32'h0);
    begin
      int stray = 0;
      for (int c = 0; c < 70; c++) begin
        @(negedge clk);
        if (ivecACK || devACK != 8'h0) stray++;
        nxt();
      end
      chk("midrst no_activity", stray, 0);
    end
    txn("post_reset", tv[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/uba_intr_arb.md
Name: uba_intr_arb

Overview:
- Unibus interrupt arbiter and vector-cycle sequencer for the UBA.
- Collects bus-request (BR4..BR7) interrupts from up to NDEV Unibus devices and drives the aggregated per-level request into the UBA interrupt-priority logic (devINTR[7:4]).
- When the CPU performs an interrupt-vector read for a PI level, it arbitrates among eligible requesters and grants exactly one device. It then waits for that device's vector and returns it to the bus interface, or returns a zero vector on no-requester or timeout.

Parameters:
- NDEV, 8, number of device request slots (1..16); slot 0 has highest priority within a BR level.
- VWIDTH, 18, vector width in bits.
- TMOWIDTH, 6, timeout counter width; timeout is 2**TMOWIDTH-1 cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- devREQ  input  NDEV  per-device interrupt request level-sensitive
- devBR  input  2*NDEV  per-device BR level, slot i in bits [2i+1:2i]; 0=BR4, 1=BR5, 2=BR6, 3=BR7
- devACK  output  NDEV  one-hot grant to the selected device
- devVECT  input  VWIDTH  vector driven by the granted device
- devVECTVAL  input  1  granted device asserts when devVECT is valid
- devINTR  output  4  bits [7:4]: registered OR of requests per BR level
- statPIH  input  3  PI assignment for BR7/BR6
- statPIL  input  3  PI assignment for BR5/BR4
- ivecREQ  input  1  one-cycle pulse: CPU vector read
- ivecPI  input  3  PI level being serviced, sampled with ivecREQ
- ivecACK  output  1  one-cycle pulse: vector cycle complete
- ivecDATA  output  VWIDTH  returned vector, valid while ivecACK=1
- ivecNONE  output  1  with ivecACK: no requester, or device timed out

Behaviour:
- Clock and reset: all flops are on the rising edge of clk. rst is synchronous active-high.
- Reset values: devACK=0, devINTR=0, ivecACK=0, ivecDATA=0, ivecNONE=0, state=IDLE, timer=0.
- devINTR[L] is registered every cycle as the OR over i of (devREQ[i] AND devBR[i]==L-4). It has 1-cycle latency and updates in all states.
- IDLE:
  - On ivecREQ, latch ivecPI into pil and go to ARB.
  - ivecREQ received in any other state is ignored; no queueing.
- ARB (one cycle):
  - BR7/BR6 are eligible iff statPIH==pil and pil!=0. BR5/BR4 are eligible iff statPIL==pil and pil!=0.
  - Winner is the highest eligible BR level with any active devREQ. Within that level, the lowest slot index wins.
  - If there is a winner: set devACK one-hot at the winner, clear timer, go to GRANT.
  - If there is no winner: pulse ivecACK=1, ivecNONE=1, ivecDATA=0, return to IDLE.
- GRANT:
  - devACK is held stable.
  - On devVECTVAL: latch devVECT into ivecDATA, pulse ivecACK=1 with ivecNONE=0, drop devACK, go to DONE.
  - Otherwise increment timer. When the timer reaches all-ones: pulse ivecACK=1, ivecNONE=1, ivecDATA=0, drop devACK, go to DONE.
  - devVECTVAL and timeout in the same cycle: devVECTVAL wins.
  - The granted device dropping devREQ during GRANT does not abort; the block still waits for devVECTVAL or timeout.
- DONE (one cycle): ivecACK returns to 0 and the state returns to IDLE. ivecDATA holds its value until the next ack.
- Latency: ivecREQ at cycle 0 → ARB at cycle 1 → devACK visible at cycle 2. A device that answers devVECTVAL in cycle 2 produces ivecACK in cycle 3. The no-winner response gives ivecACK in cycle 2.
- ivecACK is exactly one cycle wide, once per accepted ivecREQ.
- Reset in any state returns to IDLE next edge with devACK=0 and no ivecACK.
- devVECTVAL from a non-granted device, or outside GRANT, is ignored.

Test Plan:
- Reset: hold rst with devREQ=all-ones → all outputs 0. Release → devINTR reflects the request levels one cycle later.
- Priority ordering: statPIH=3, statPIL=3; slot 5 requests BR7, slot 2 requests BR4, slot 1 requests BR7. ivecREQ with ivecPI=3 → devACK=8'b00000010 at cycle 2. Device answers vector 0o254 → ivecACK at cycle 3 with ivecDATA=0o254 and ivecNONE=0.
- PI mismatch: statPIH=5, statPIL=2; only BR6 requesters present. ivecREQ with ivecPI=2 → no devACK; ivecACK at cycle 2 with ivecNONE=1 and ivecDATA=0.
- Timeout: slot 0 granted and never asserts devVECTVAL → ivecACK with ivecNONE=1 after 63 GRANT cycles, devACK cleared in the same cycle. A second ivecREQ issued during GRANT produces no second ivecACK.
- Simultaneous devVECTVAL and timeout on the final cycle → ivecNONE=0 and ivecDATA equals devVECT.
- Reset mid-GRANT: rst pulsed while devACK is asserted → devACK=0 next cycle, no ivecACK, state=IDLE. A following ivecREQ is serviced normally.
